// File: rtl/uart_tx_fifo_drain_if.sv
// Connects the FIFO read port and the UART TX pin side of uart_tx_fifo_drain.
// The drain is the master; the FIFO/board side is the slave.
interface uart_tx_fifo_drain_if #(
  parameter int unsigned c_WIDTH = 7
);
  logic               i_Tx_Enable;
  logic               i_Fifo_Empty;
  logic [c_WIDTH:0]   i_Fifo_Data;
  logic               o_Fifo_Read_En;
  logic               o_Tx_Serial;
  logic               o_Tx_Active;
  logic               o_Tx_Done;

  modport master (
    input  i_Tx_Enable,
    input  i_Fifo_Empty,
    input  i_Fifo_Data,
    output o_Fifo_Read_En,
    output o_Tx_Serial,
    output o_Tx_Active,
    output o_Tx_Done
  );

  modport slave (
    output i_Tx_Enable,
    output i_Fifo_Empty,
    output i_Fifo_Data,
    input  o_Fifo_Read_En,
    input  o_Tx_Serial,
    input  o_Tx_Active,
    input  o_Tx_Done
  );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// Pops bytes from a FIFO (never while empty) and shifts each out as UART 8N1,
// LSB first, with registered line/status outputs.
module uart_tx_fifo_drain #(
  parameter int unsigned c_CLKS_PER_BIT = 208,
  parameter int unsigned c_WIDTH        = 7
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  uart_tx_fifo_drain_if.master bus
);

  localparam int unsigned CNT_W = (c_CLKS_PER_BIT < 2) ? 1 : $clog2(c_CLKS_PER_BIT);
  localparam int unsigned BIT_W = (c_WIDTH < 1) ? 1 : $clog2(c_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(c_CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(c_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e             state_q,     state_d;
  logic [CNT_W-1:0]   clk_cnt_q,   clk_cnt_d;
  logic [BIT_W-1:0]   bit_idx_q,   bit_idx_d;
  logic [c_WIDTH:0]   shift_q,     shift_d;
  logic               tx_serial_q, tx_serial_d;
  logic               tx_active_q, tx_active_d;
  logic               tx_done_q,   tx_done_d;
  logic               clk_last;

  assign clk_last = (clk_cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_Tx_Enable && !bus.i_Fifo_Empty) state_d = S_READ;
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        // FIFO read data is valid exactly one cycle after the strobe.
        shift_d   = bus.i_Fifo_Data;
        clk_cnt_d = '0;
        state_d   = S_START;
      end
      S_START: begin
        if (clk_last) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (clk_last) begin
          clk_cnt_d = '0;
          if (bit_idx_q == BIT_LAST) state_d = S_STOP;
          else                       bit_idx_d = bit_idx_q + BIT_W'(1);
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (clk_last) begin
          clk_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are derived from the next state so they line up with it.
    unique case (state_d)
      S_START: tx_serial_d = 1'b0;
      S_DATA:  tx_serial_d = shift_d[bit_idx_d];
      default: tx_serial_d = 1'b1;
    endcase
    tx_active_d = (state_d != S_IDLE);
    tx_done_d   = (state_q == S_STOP) && (state_d == S_IDLE);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      // NOTE: the shift register is a plain datapath register, so clearing it on reset is cheap and keeps the line deterministic.
      shift_q     <= '0;
      tx_serial_q <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      tx_serial_q <= tx_serial_d;
      tx_active_q <= tx_active_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign bus.o_Fifo_Read_En = (state_q == S_READ);
  assign bus.o_Tx_Serial    = tx_serial_q;
  assign bus.o_Tx_Active    = tx_active_q;
  assign bus.o_Tx_Done      = tx_done_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed and random checks of uart_tx_fifo_drain against a queue-based FIFO
// and a bit-slot UART receiver model.
module tb_uart_tx_fifo_drain;

  localparam int CLKS = 4;
  localparam int W    = 7;

  logic clk;
  logic rst;

  uart_tx_fifo_drain_if #(.c_WIDTH(W)) bus ();

  uart_tx_fifo_drain #(
    .c_CLKS_PER_BIT(CLKS),
    .c_WIDTH       (W)
  ) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int cyc = 0;
  int reads = 0;
  int underflows = 0;
  int framing_errs = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] rx_q[$];
  int         starts[$];
  logic       rx_busy = 1'b0;
  int         rx_start = 0;
  logic [7:0] rx_byte = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected line level at observation offset off after the edge that took the byte.
  function automatic logic exp_line(input logic [7:0] b, input int off);
    if (off >= 2 && off < 2 + CLKS) return 1'b0;
    if (off >= 2 + CLKS && off < 2 + 9 * CLKS) return b[(off - 2 - CLKS) / CLKS];
    return 1'b1;
  endfunction

  // One clock: edge, then observe at the falling edge and update FIFO and receiver models.
  task automatic tick();
    int off;
    int slot;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (bus.o_Fifo_Read_En === 1'b1) begin
      reads++;
      if (fifo_q.size() == 0) underflows++;
      else bus.i_Fifo_Data = fifo_q.pop_front();
    end
    bus.i_Fifo_Empty = (fifo_q.size() == 0);
    if (!rx_busy) begin
      if (bus.o_Tx_Serial === 1'b0) begin
        rx_busy  = 1'b1;
        rx_start = cyc;
        starts.push_back(cyc);
      end
    end else begin
      off = cyc - rx_start;
      if (off % CLKS == CLKS / 2) begin
        slot = off / CLKS;
        if (slot >= 1 && slot <= 8) rx_byte[slot-1] = bus.o_Tx_Serial;
        else if (slot == 9) begin
          if (bus.o_Tx_Serial === 1'b1) rx_q.push_back(rx_byte);
          else framing_errs++;
          rx_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    bus.i_Fifo_Empty = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("wait_rx_count", rx_q.size(), n);
  endtask

  initial begin
    int base_reads;
    int kk;
    logic [7:0] sent[$];
    logic [7:0] b;

    rst = 1'b1;
    bus.i_Tx_Enable  = 1'b1;
    bus.i_Fifo_Empty = 1'b1;
    bus.i_Fifo_Data  = '0;
    repeat (3) tick();
    check("rst_serial", bus.o_Tx_Serial, 1);
    check("rst_active", bus.o_Tx_Active, 0);
    check("rst_done",   bus.o_Tx_Done, 0);
    check("rst_rd",     bus.o_Fifo_Read_En, 0);
    rst = 1'b0;

    // Empty FIFO for 100 cycles: nothing happens.
    for (int i = 0; i < 100; i++) begin
      tick();
      check("empty_rd",     bus.o_Fifo_Read_En, 0);
      check("empty_serial", bus.o_Tx_Serial, 1);
      check("empty_active", bus.o_Tx_Active, 0);
    end

    // Single 0xA5 frame, cycle-exact.
    push_byte(8'hA5);
    for (int off = 0; off < 46; off++) begin
      tick();
      check("a5_rd",     bus.o_Fifo_Read_En, (off == 0) ? 1 : 0);
      check("a5_serial", bus.o_Tx_Serial, exp_line(8'hA5, off));
      check("a5_active", bus.o_Tx_Active, (off <= 41) ? 1 : 0);
      check("a5_done",   bus.o_Tx_Done, (off == 42) ? 1 : 0);
    end
    check("a5_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("a5_rx_byte", rx_q.pop_front(), 8'hA5);

    // Back-to-back 0x00 then 0xFF.
    rx_q.delete();
    starts.delete();
    base_reads = reads;
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_rx(2, 200);
    repeat (10) tick();
    check("b2b_reads", reads - base_reads, 2);
    if (rx_q.size() >= 2) begin
      check("b2b_byte0", rx_q[0], 8'h00);
      check("b2b_byte1", rx_q[1], 8'hFF);
    end
    if (starts.size() >= 2) check("b2b_start_spacing", starts[1] - starts[0], 10 * CLKS + 3);

    // Enable gating.
    rx_q.delete();
    starts.delete();
    bus.i_Tx_Enable = 1'b0;
    base_reads = reads;
    push_byte(8'h3C);
    push_byte(8'h99);
    repeat (20) tick();
    check("dis_reads", reads - base_reads, 0);
    check("dis_serial", bus.o_Tx_Serial, 1);
    bus.i_Tx_Enable = 1'b1;
    kk = cyc + 1;
    repeat (10) tick();
    bus.i_Tx_Enable = 1'b0;
    if (starts.size() >= 1) check("en_start_cycle", starts[0], kk + 2);
    else check("en_start_seen", starts.size(), 1);
    wait_rx(1, 100);
    repeat (60) tick();
    check("en_drop_reads", reads - base_reads, 1);
    if (rx_q.size() >= 1) check("en_byte", rx_q[0], 8'h3C);
    check("en_fifo_left", fifo_q.size(), 1);

    // Reset during DATA bit 3: 0x99 is discarded, 0x5A follows.
    rx_q.delete();
    push_byte(8'h5A);
    bus.i_Tx_Enable = 1'b1;
    kk = cyc + 1;
    while (cyc < kk + 19) tick();
    rst = 1'b1;
    rx_busy = 1'b0;
    tick();
    check("mid_rst_serial", bus.o_Tx_Serial, 1);
    check("mid_rst_active", bus.o_Tx_Active, 0);
    check("mid_rst_rd",     bus.o_Fifo_Read_En, 0);
    rst = 1'b0;
    wait_rx(1, 100);
    if (rx_q.size() >= 1) check("post_rst_byte", rx_q[0], 8'h5A);

    // Random traffic.
    repeat (50) tick();
    rx_q.delete();
    for (int i = 0; i < 50; i++) begin
      b = 8'($urandom_range(0, 255));
      sent.push_back(b);
      push_byte(b);
      repeat ($urandom_range(0, 60)) tick();
    end
    wait_rx(50, 50 * 50 + 200);
    for (int i = 0; i < 50 && i < rx_q.size(); i++) check($sformatf("rand_byte_%0d", i), rx_q[i], sent[i]);
    check("rand_fifo_drained", fifo_q.size(), 0);
    check("underflows", underflows, 0);
    check("framing_errs", framing_errs, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
Downstream consumer of the byte FIFO. It pops one byte at a time from the FIFO and serialises it as UART 8N1 (1 start bit, 8 data bits LSB first, 1 stop bit) on a single TX line. It sits between the FIFO read port and the board TX pin. It guarantees that a read is never issued while the FIFO reports empty.

Parameters:
c_CLKS_PER_BIT, 208, clock cycles per UART bit (24 MHz / 115200 baud); minimum legal value 2.
c_WIDTH, 7, MSB index of the data byte; data is c_WIDTH+1 bits wide and must match the FIFO data width.

Ports:
i_Clock  input  1  system clock, rising-edge.
i_Reset  input  1  reset; synchronous, active-high.
i_Tx_Enable  input  1  when high, new frames may start; sampled only in IDLE.
i_Fifo_Empty  input  1  FIFO empty flag.
i_Fifo_Data  input  c_WIDTH+1  FIFO read data; valid the cycle after o_Fifo_Read_En is high.
o_Fifo_Read_En  output  1  one-cycle FIFO read strobe.
o_Tx_Serial  output  1  UART line; idles high.
o_Tx_Active  output  1  high from READ through the end of STOP.
o_Tx_Done  output  1  one-cycle pulse after each completed stop bit.

Behaviour:
- Reset (synchronous, i_Reset=1 at a rising edge):
  - state=IDLE; o_Tx_Serial=1; o_Fifo_Read_En=0; o_Tx_Active=0; o_Tx_Done=0.
  - Bit counter, clock counter and shift register all cleared to 0.
- States: IDLE, READ, WAIT, START, DATA, STOP.
- IDLE:
  - o_Tx_Serial=1, o_Tx_Active=0.
  - If i_Tx_Enable=1 and i_Fifo_Empty=0, go to READ; otherwise stay.
- READ (exactly 1 cycle):
  - o_Fifo_Read_En=1 (decoded from state); o_Tx_Active=1.
  - Always go to WAIT.
- WAIT (exactly 1 cycle):
  - Latch i_Fifo_Data into the shift register; clear the clock counter.
  - Go to START.
- START: o_Tx_Serial=0 for c_CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - o_Tx_Serial = shift register bit[index] for c_CLKS_PER_BIT cycles per bit.
  - Index increments 0..c_WIDTH; after bit c_WIDTH, go to STOP.
- STOP:
  - o_Tx_Serial=1 for c_CLKS_PER_BIT cycles, then go to IDLE.
  - o_Tx_Done=1 during the first IDLE cycle only.
- Outputs: o_Tx_Serial, o_Tx_Active and o_Tx_Done are registered. o_Fifo_Read_En is glitch-free because it is a state decode.
- Latency: if IDLE samples non-empty at edge k, then:
  - o_Fifo_Read_En is high in cycle k+1.
  - Data is latched at edge k+2.
  - The start bit begins at cycle k+3.
  - A frame occupies 10*c_CLKS_PER_BIT cycles on the line.
- Back-to-back frames:
  - The Done-pulse cycle is an IDLE cycle and may itself decide to go to READ.
  - Minimum line-high gap between consecutive stop-bit ends and start bits: 3 cycles (IDLE, READ, WAIT) beyond the stop bit.
- Empty handling:
  - No read is ever issued when i_Fifo_Empty=1, so no FIFO underflow is caused.
  - At most one read per frame. The FIFO empty flag updates one edge after the read, so it is valid again well before the next IDLE.
- i_Tx_Enable deasserted mid-frame: the current frame completes normally; no new frame starts until the enable is high again.
- Reset mid-frame:
  - The line returns high at the next edge and the in-flight byte is discarded.
  - The FIFO is unaffected; its reset is independent.
- Counter widths: the clock counter is wide enough for c_CLKS_PER_BIT-1; the bit index is wide enough for c_WIDTH. No wrap occurs in the counters except the defined rollover at terminal count.

Test Plan (c_CLKS_PER_BIT=4, c_WIDTH=7):
- Reset, then hold i_Fifo_Empty=1 for 100 cycles -> o_Fifo_Read_En never asserted; o_Tx_Serial=1; o_Tx_Active=0.
- One byte 0xA5 ready (empty drops at edge k) -> Read_En high at cycle k+1 only; line low from k+3 for 4 cycles; data bits 1,0,1,0,0,1,0,1 at 4 cycles each; stop high 4 cycles; o_Tx_Done pulses at cycle k+43.
- Bytes 0x00 then 0xFF queued -> exactly two Read_En pulses; 3-cycle high gap between the first stop bit and the second start bit; decoded bytes 0x00, 0xFF.
- i_Tx_Enable=0 while the FIFO is non-empty -> no reads. Raise enable -> transmission starts 3 cycles later. Drop enable mid-frame -> that frame completes and no further read occurs.
- Assert i_Reset during DATA bit 3 -> o_Tx_Serial=1, o_Tx_Active=0 at the next edge. Release reset with the FIFO non-empty -> the next byte is fetched and sent from its start bit.
- Random 50 bytes through FIFO+drain with a UART receiver model -> all bytes received in order; no FIFO underflow flag ever set.
